// File: rtl/div_share_arb_if.sv
// Bus bundle for div_share_arb: requester-side request/response signals and
// the PCPI master port toward the shared iterative divider.
interface div_share_arb_if #(
   parameter int NREQ = 2
) ();
   logic [NREQ-1:0]    req_valid;
   logic [2*NREQ-1:0]  req_op;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic [NREQ-1:0]    rsp_valid;
   logic [31:0]        rsp_data;
   logic               rsp_err;
   logic               err_sticky;
   logic               m_pcpi_valid;
   logic [31:0]        m_pcpi_insn;
   logic [31:0]        m_pcpi_rs1;
   logic [31:0]        m_pcpi_rs2;
   logic               m_pcpi_wr;
   logic               m_pcpi_ready;
   logic               m_pcpi_wait;
   logic [31:0]        m_pcpi_rd;

   // Arbiter view
   modport slave (
      input  req_valid, req_op, req_a, req_b,
      output rsp_valid, rsp_data, rsp_err, err_sticky,
      output m_pcpi_valid, m_pcpi_insn, m_pcpi_rs1, m_pcpi_rs2,
      input  m_pcpi_wr, m_pcpi_ready, m_pcpi_wait, m_pcpi_rd
   );

   // Environment view: requesters plus the divider
   modport master (
      output req_valid, req_op, req_a, req_b,
      input  rsp_valid, rsp_data, rsp_err, err_sticky,
      input  m_pcpi_valid, m_pcpi_insn, m_pcpi_rs1, m_pcpi_rs2,
      output m_pcpi_wr, m_pcpi_ready, m_pcpi_wait, m_pcpi_rd
   );
endinterface

// File: rtl/div_share_arb.sv
// Round-robin sharing of one PCPI divider between NREQ requesters, with a
// one-entry last-result cache and a divider-timeout abort.
//
// state | meaning
// IDLE  | pick next requester round-robin, latch its op/a/b, check cache
// BUSY  | m_pcpi_valid high, waiting for ready or timeout
// RESP  | one-cycle rsp_valid pulse to the granted requester
// DRAIN | after a timeout, absorb a late ready or wait out TIMEOUT cycles
module div_share_arb #(
   parameter int NREQ     = 2,
   parameter int TIMEOUT  = 64,
   parameter bit CACHE_EN = 1'b1
) (
   input logic            clk,
   input logic            resetn,
   div_share_arb_if.slave bus
);
   localparam int GW = (NREQ > 2) ? 2 : 1;
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [GW-1:0]   g_q, g_d;
   logic [GW-1:0]   last_grant_q, last_grant_d;
   logic [1:0]      op_q, op_d;
   logic [31:0]     rs1_q, rs1_d;
   logic [31:0]     rs2_q, rs2_d;
   logic            m_pcpi_valid_q, m_pcpi_valid_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic            rsp_err_q, rsp_err_d;
   logic            err_sticky_q, err_sticky_d;
   logic            c_valid_q, c_valid_d;
   logic [65:0]     c_tag_q, c_tag_d;
   logic [31:0]     c_data_q, c_data_d;

   logic            found;
   logic [GW-1:0]   pick;
   logic [1:0]      pick_op;
   logic [31:0]     pick_a;
   logic [31:0]     pick_b;
   logic            unused_pcpi;

   // ready always implies wr for this divider, and wait carries no extra information
   assign unused_pcpi = bus.m_pcpi_wr ^ bus.m_pcpi_wait;

   assign pick_op = bus.req_op[{pick, 1'b0} +: 2];
   assign pick_a  = bus.req_a[{pick, 5'b0} +: 32];
   assign pick_b  = bus.req_b[{pick, 5'b0} +: 32];

   // Round-robin search starting just above the last served requester
   always_comb begin : rr_search
      logic [GW-1:0] cand;
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = GW'((int'(last_grant_q) + k) % NREQ);
         if (!found && bus.req_valid[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state and next-output computation for the sequencer
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      g_d            = g_q;
      last_grant_d   = last_grant_q;
      op_d           = op_q;
      rs1_d          = rs1_q;
      rs2_d          = rs2_q;
      m_pcpi_valid_d = m_pcpi_valid_q;
      rsp_valid_d    = '0;
      rsp_data_d     = rsp_data_q;
      rsp_err_d      = rsp_err_q;
      err_sticky_d   = err_sticky_q;
      c_valid_d      = c_valid_q;
      c_tag_d        = c_tag_q;
      c_data_d       = c_data_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               g_d   = pick;
               op_d  = pick_op;
               rs1_d = pick_a;
               rs2_d = pick_b;
               if (CACHE_EN && c_valid_q && (c_tag_q == {pick_op, pick_a, pick_b})) begin
                  rsp_data_d        = c_data_q;
                  rsp_err_d         = 1'b0;
                  rsp_valid_d[pick] = 1'b1;
                  state_d           = RESP;
               end else begin
                  cnt_d          = '0;
                  m_pcpi_valid_d = 1'b1;
                  state_d        = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.m_pcpi_ready) begin
               rsp_data_d       = bus.m_pcpi_rd;
               rsp_err_d        = 1'b0;
               c_tag_d          = {op_q, rs1_q, rs2_q};
               c_data_d         = bus.m_pcpi_rd;
               c_valid_d        = 1'b1;
               m_pcpi_valid_d   = 1'b0;
               rsp_valid_d[g_q] = 1'b1;
               state_d          = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rsp_data_d       = '0;
               rsp_err_d        = 1'b1;
               err_sticky_d     = 1'b1;
               c_valid_d        = 1'b0;
               cnt_d            = '0;
               m_pcpi_valid_d   = 1'b0;
               rsp_valid_d[g_q] = 1'b1;
               state_d          = RESP;
            end
         end
         RESP: begin
            last_grant_d = g_q;
            state_d      = rsp_err_q ? DRAIN : IDLE;
         end
         DRAIN: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.m_pcpi_ready || (cnt_q == CNT_LAST)) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         g_q            <= '0;
         last_grant_q   <= GW'(NREQ - 1);
         op_q           <= '0;
         rs1_q          <= '0;
         rs2_q          <= '0;
         m_pcpi_valid_q <= 1'b0;
         rsp_valid_q    <= '0;
         rsp_data_q     <= '0;
         rsp_err_q      <= 1'b0;
         err_sticky_q   <= 1'b0;
         c_valid_q      <= 1'b0;
         c_tag_q        <= '0;
         c_data_q       <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         g_q            <= g_d;
         last_grant_q   <= last_grant_d;
         op_q           <= op_d;
         rs1_q          <= rs1_d;
         rs2_q          <= rs2_d;
         m_pcpi_valid_q <= m_pcpi_valid_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_data_q     <= rsp_data_d;
         rsp_err_q      <= rsp_err_d;
         err_sticky_q   <= err_sticky_d;
         c_valid_q      <= c_valid_d;
         c_tag_q        <= c_tag_d;
         c_data_q       <= c_data_d;
      end
   end

   assign bus.rsp_valid    = rsp_valid_q;
   assign bus.rsp_data     = rsp_data_q;
   assign bus.rsp_err      = rsp_err_q;
   assign bus.err_sticky   = err_sticky_q;
   assign bus.m_pcpi_valid = m_pcpi_valid_q;
   assign bus.m_pcpi_insn  = {7'b0000001, 10'b0, 1'b1, op_q, 5'b0, 7'b0110011};
   assign bus.m_pcpi_rs1   = rs1_q;
   assign bus.m_pcpi_rs2   = rs2_q;
endmodule

// File: tb/tb_div_share_arb.sv
// Scoreboard bench for div_share_arb: requester tasks push expected responses
// per requester, a monitor pops them when rsp_valid pulses, and a behavioural
// RV32M divider with random latency serves the PCPI port.
module tb_div_share_arb;
   localparam int NREQ    = 2;
   localparam int TIMEOUT = 64;

   typedef struct packed {
      logic [31:0] data;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   div_share_arb_if #(.NREQ(NREQ)) bus ();

   div_share_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CACHE_EN(1'b1)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   logic        rq_v  [NREQ];
   logic [1:0]  rq_op [NREQ];
   logic [31:0] rq_a  [NREQ];
   logic [31:0] rq_b  [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign bus.req_valid[gi]       = rq_v[gi];
      assign bus.req_op[2*gi +: 2]   = rq_op[gi];
      assign bus.req_a[32*gi +: 32]  = rq_a[gi];
      assign bus.req_b[32*gi +: 32]  = rq_b[gi];
   end

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t exp_q [NREQ][$];
   int   rsp_seq [$];
   int   last_served = NREQ - 1;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h cyc=%0d", name, act, req, cyc);
      end
   endfunction

   // RV32M divide semantics, including divide-by-zero and signed overflow
   function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic               ovf;
      sa  = a;
      sb  = b;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
         2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'd2:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Divider model: accepts on m_pcpi_valid, answers after a random latency
   logic        dead = 1'b0;
   logic        dbusy = 1'b0;
   int          dlat = 0;
   logic [31:0] dres = '0;
   logic [31:0] d_insn = '0;
   logic [31:0] d_rs1 = '0;
   logic [31:0] d_rs2 = '0;
   int          issue_cnt = 0;
   int          issue_cyc = 0;
   int          ready_cyc = 0;

   always @(negedge clk) begin
      bus.m_pcpi_ready = 1'b0;
      bus.m_pcpi_wr    = 1'b0;
      if (!resetn || !bus.m_pcpi_valid) begin
         dbusy = 1'b0;
      end else if (!dbusy) begin
         dbusy  = 1'b1;
         dlat   = $urandom_range(8, 1);
         d_insn = bus.m_pcpi_insn;
         d_rs1  = bus.m_pcpi_rs1;
         d_rs2  = bus.m_pcpi_rs2;
         dres   = ref_div(d_insn[13:12], d_rs1, d_rs2);
         issue_cnt++;
         issue_cyc = cyc;
         chk("insn_fixed_bits", d_insn & ~32'h0000_3000, 32'h0200_4033);
      end else begin
         chk("pcpi_insn_stable", bus.m_pcpi_insn, d_insn);
         chk("pcpi_rs1_stable", bus.m_pcpi_rs1, d_rs1);
         chk("pcpi_rs2_stable", bus.m_pcpi_rs2, d_rs2);
         if (!dead) begin
            dlat--;
            if (dlat == 0) begin
               bus.m_pcpi_ready = 1'b1;
               bus.m_pcpi_wr    = 1'b1;
               ready_cyc        = cyc;
            end
         end
      end
      bus.m_pcpi_rd   = dres;
      bus.m_pcpi_wait = dbusy;
   end

   // Monitor: pop and compare whenever a response pulse appears
   always @(negedge clk) begin
      exp_t e;
      chk("rsp_onehot", 32'($countones(bus.rsp_valid) <= 1), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
         if (bus.rsp_valid[i]) begin
            chk("rsp_was_expected", 32'(exp_q[i].size() != 0), 32'd1);
            if (exp_q[i].size() != 0) begin
               e = exp_q[i].pop_front();
               chk("rsp_data", bus.rsp_data, e.data);
               chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
            rsp_seq.push_back(i);
            last_served = i;
         end
      end
   end

   task automatic req_op(input int i, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit tmo, input bit scramble, output int gcyc, output int rcyc);
      exp_t e;
      int   n;
      e.data = tmo ? 32'd0 : ref_div(op, a, b);
      e.err  = tmo;
      exp_q[i].push_back(e);
      rq_op[i] = op;
      rq_a[i]  = a;
      rq_b[i]  = b;
      rq_v[i]  = 1'b1;
      gcyc     = cyc;
      n        = 0;
      do begin
         @(negedge clk);
         n++;
         if (scramble && n == 1) begin
            rq_op[i] = 2'($urandom);
            rq_a[i]  = $urandom;
            rq_b[i]  = $urandom;
         end
      end while (!bus.rsp_valid[i] && n < 400);
      chk("rsp_within_bound", 32'(bus.rsp_valid[i]), 32'd1);
      rcyc    = cyc;
      rq_v[i] = 1'b0;
   endtask

   logic [1:0]  pool_op [4] = '{2'd0, 2'd2, 2'd1, 2'd3};
   logic [31:0] pool_a  [4] = '{32'h8000_0000, 32'h8000_0000, 32'd1000, 32'hFFFF_FFFF};
   logic [31:0] pool_b  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'd16};

   task automatic rand_proc(input int i);
      int g;
      int r;
      int p;
      repeat (8) begin
         repeat ($urandom_range(2, 0)) @(negedge clk);
         if ($urandom_range(1, 0) == 1) begin
            p = $urandom_range(3, 0);
            req_op(i, pool_op[p], pool_a[p], pool_b[p], 1'b0, 1'b0, g, r);
         end else begin
            req_op(i, 2'($urandom), $urandom, 32'($urandom_range(40, 0)), 1'b0, 1'b0, g, r);
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rsp_data"}, bus.rsp_data, 32'd0);
      chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
      chk({tag, "_err_sticky"}, 32'(bus.err_sticky), 32'd0);
      chk({tag, "_pcpi_valid"}, 32'(bus.m_pcpi_valid), 32'd0);
   endtask

   initial begin
      int g;
      int r;
      int n;
      int rt;
      int start;
      for (int i = 0; i < NREQ; i++) begin
         rq_v[i]  = 1'b0;
         rq_op[i] = '0;
         rq_a[i]  = '0;
         rq_b[i]  = '0;
      end
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      resetn = 1'b1;
      @(negedge clk);

      // Single op DIV -7/2, inputs scrambled once in flight, then REM same operands
      n = issue_cnt;
      req_op(0, 2'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, g, r);
      chk("div_insn", d_insn, 32'h0200_4033);
      chk("miss_issue_latency", issue_cyc, g + 1);
      chk("miss_rsp_latency", r, ready_cyc + 1);
      @(negedge clk);
      req_op(0, 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, g, r);
      chk("rem_same_ab_misses", issue_cnt, n + 2);

      // Cache: miss, identical hit, then changed divisor misses
      @(negedge clk);
      req_op(1, 2'd1, 32'd100, 32'd7, 1'b0, 1'b0, g, r);
      @(negedge clk);
      n = issue_cnt;
      req_op(1, 2'd1, 32'd100, 32'd7, 1'b0, 1'b0, g, r);
      chk("hit_rsp_latency", r, g + 1);
      chk("hit_no_pcpi", issue_cnt, n);
      @(negedge clk);
      req_op(1, 2'd1, 32'd100, 32'd8, 1'b0, 1'b0, g, r);
      chk("changed_b_misses", issue_cnt, n + 1);

      // Divide by zero passes through
      @(negedge clk);
      req_op(0, 2'd0, 32'd5, 32'd0, 1'b0, 1'b0, g, r);
      req_op(1, 2'd3, 32'd5, 32'd0, 1'b0, 1'b0, g, r);

      // Fairness: both held continuously, grants must alternate
      rsp_seq.delete();
      start = (last_served + 1) % NREQ;
      fork
         begin
            int g0;
            int r0;
            repeat (4) req_op(0, 2'd0, $urandom, $urandom, 1'b0, 1'b0, g0, r0);
         end
         begin
            int g1;
            int r1;
            repeat (4) req_op(1, 2'd3, $urandom, $urandom, 1'b0, 1'b0, g1, r1);
         end
      join
      chk("fair_count", rsp_seq.size(), 8);
      for (int k = 0; k < rsp_seq.size(); k++) chk("fair_order", rsp_seq[k], (start + k) % NREQ);

      // Randomized traffic with a small operand pool to provoke cache hits
      fork
         rand_proc(0);
         rand_proc(1);
      join

      // Timeout: fill cache, time out, drain, then the cached op must miss
      @(negedge clk);
      req_op(0, 2'd2, 32'd1234, 32'd10, 1'b0, 1'b0, g, r);
      @(negedge clk);
      dead = 1'b1;
      req_op(0, 2'd0, 32'd77, 32'd5, 1'b1, 1'b0, g, rt);
      chk("timeout_latency", rt, issue_cyc + TIMEOUT);
      chk("err_sticky_set", 32'(bus.err_sticky), 32'd1);
      dead = 1'b0;
      n = issue_cnt;
      req_op(1, 2'd2, 32'd1234, 32'd10, 1'b0, 1'b0, g, r);
      chk("drain_then_issue", issue_cyc, rt + TIMEOUT + 2);
      chk("cache_invalidated", issue_cnt, n + 1);
      chk("err_sticky_holds", 32'(bus.err_sticky), 32'd1);

      // Reset during BUSY: no pulse, outputs back to reset values, cache cold
      @(negedge clk);
      dead     = 1'b1;
      n        = issue_cnt;
      rq_op[0] = 2'd1;
      rq_a[0]  = 32'd99;
      rq_b[0]  = 32'd4;
      rq_v[0]  = 1'b1;
      for (int k = 0; k < 10 && issue_cnt == n; k++) @(negedge clk);
      chk("rst_case_issued", issue_cnt, n + 1);
      repeat (5) @(negedge clk);
      resetn  = 1'b0;
      rq_v[0] = 1'b0;
      @(negedge clk);
      chk_reset_outputs("mid_busy_reset");
      @(negedge clk);
      resetn = 1'b1;
      dead   = 1'b0;
      @(negedge clk);
      n = issue_cnt;
      req_op(1, 2'd2, 32'd1234, 32'd10, 1'b0, 1'b0, g, r);
      chk("post_reset_miss", issue_cnt, n + 1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end
endmodule
